// File: rtl/row_packet_tx.sv
// row_packet_tx: packet FIFO feeding a UART-style serialiser (start, 16 data bits MSB first, stop).
// Define ROW_PACKET_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high; pops the FIFO head when tx_enable is high and a packet is buffered
// START  | start bit (low) for CLK_DIV cycles
// DATA   | 16 data bits, MSB first, CLK_DIV cycles each
// PARITY | even parity of the data bits, CLK_DIV cycles (only with ROW_PACKET_TX_PARITY_EN)
// STOP   | stop bit (high) for CLK_DIV cycles
module row_packet_tx #(
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4,
   parameter int CLK_DIV    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       pkt_in,
   input  logic              pkt_valid,
   input  logic              tx_enable,
   input  logic              clear_ovf,
   output logic              serial_out,
   output logic              frame_active,
   output logic [ADDR_W:0]   fifo_level,
   output logic              fifo_full,
   output logic              overflow_sticky,
   output logic [7:0]        drop_count
);

   localparam int                DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [ADDR_W:0]   FULL_LVL   = (ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   ALMOST_LVL = (ADDR_W+1)'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef ROW_PACKET_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t              state;
   logic [15:0]         mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_ptr;
   logic [15:0]         shift_reg;
   logic [3:0]          bit_cnt;
   logic [DIV_W-1:0]    div_cnt;
   logic                div_last;
   logic                pop;
   logic                space;
   logic                push;
   logic                drop;

   assign div_last = (div_cnt == DIV_LAST);
   assign pop      = (state == IDLE) && tx_enable && (fifo_level != '0);
   assign space    = (fifo_level < FULL_LVL) || pop;
   assign push     = pkt_valid && space;
   assign drop     = pkt_valid && !space;

   // Storage carries no reset; validity is tracked by the pointers and level alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pkt_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         fifo_full  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            fifo_level <= fifo_level + 1'b1;
            fifo_full  <= (fifo_level == ALMOST_LVL);
         end else if (pop && !push) begin
            fifo_level <= fifo_level - 1'b1;
            fifo_full  <= 1'b0;
         end
      end
   end

   // A drop in the same cycle as a clear wins, so the new loss is never hidden.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_sticky <= 1'b0;
         drop_count      <= '0;
      end else if (drop) begin
         overflow_sticky <= 1'b1;
         if (clear_ovf) begin
            drop_count <= 8'd1;
         end else if (drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
         end
      end else if (clear_ovf) begin
         overflow_sticky <= 1'b0;
         drop_count      <= '0;
      end
   end

`ifdef ROW_PACKET_TX_PARITY_EN
   logic parity_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_bit <= 1'b0;
      end else if (pop) begin
         parity_bit <= ^mem[rd_ptr];
      end
   end
`endif

   // serial_out is loaded with the level of the state being entered, so it is always a flop output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         div_cnt      <= '0;
         serial_out   <= 1'b1;
         frame_active <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  shift_reg    <= mem[rd_ptr];
                  state        <= START;
                  div_cnt      <= '0;
                  serial_out   <= 1'b0;
                  frame_active <= 1'b1;
               end
            end
            START: begin
               if (div_last) begin
                  state      <= DATA;
                  div_cnt    <= '0;
                  bit_cnt    <= '0;
                  serial_out <= shift_reg[15];
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            DATA: begin
               if (div_last) begin
                  div_cnt <= '0;
                  if (bit_cnt == 4'd15) begin
`ifdef ROW_PACKET_TX_PARITY_EN
                     state      <= PARITY;
                     serial_out <= parity_bit;
`else
                     state      <= STOP;
                     serial_out <= 1'b1;
`endif
                  end else begin
                     shift_reg  <= {shift_reg[14:0], 1'b0};
                     serial_out <= shift_reg[14];
                     bit_cnt    <= bit_cnt + 4'd1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
`ifdef ROW_PACKET_TX_PARITY_EN
            PARITY: begin
               if (div_last) begin
                  state      <= STOP;
                  div_cnt    <= '0;
                  serial_out <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (div_last) begin
                  state        <= IDLE;
                  div_cnt      <= '0;
                  serial_out   <= 1'b1;
                  frame_active <= 1'b0;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            default: begin
               state        <= IDLE;
               div_cnt      <= '0;
               serial_out   <= 1'b1;
               frame_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_row_packet_tx.sv
// Bench for row_packet_tx: directed vector table, hand-written frame sequences and a random run
// compared every cycle against a queue-based model of the FIFO and the expected line waveform.
module tb_row_packet_tx;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int D     = 4;
`ifdef ROW_PACKET_TX_PARITY_EN
   localparam int FL = 19 * D;
`else
   localparam int FL = 18 * D;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   pkt_in;
   logic          pkt_valid;
   logic          tx_enable;
   logic          clear_ovf;
   logic          serial_out;
   logic          frame_active;
   logic [AW:0]   fifo_level;
   logic          fifo_full;
   logic          overflow_sticky;
   logic [7:0]    drop_count;

   int checks = 0;
   int errors = 0;

   row_packet_tx #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .CLK_DIV(D)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pkt_in          (pkt_in),
      .pkt_valid       (pkt_valid),
      .tx_enable       (tx_enable),
      .clear_ovf       (clear_ovf),
      .serial_out      (serial_out),
      .frame_active    (frame_active),
      .fifo_level      (fifo_level),
      .fifo_full       (fifo_full),
      .overflow_sticky (overflow_sticky),
      .drop_count      (drop_count)
   );

   always #5 clk = ~clk;

   // Reference model: packet queue plus the queue of line levels still to be shown.
   logic [15:0] m_fifo [$];
   bit          m_line [$];
   bit          m_active;
   bit          m_serial;
   bit          m_sticky;
   int          m_drops;

   int q_ser [$];
   int q_act [$];
   int q_lvl [$];

   typedef struct {
      bit          v;
      logic [15:0] d;
      bit          en;
      bit          clr;
      int          lvl;
      bit          full;
      bit          sticky;
      int          drops;
   } vec_t;

   vec_t vt [$];
   bit   a_bits [16] = '{0,0,1,0,1,0,1,0,0,1,0,1,1,0,1,1};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int qget(input int q [$], input int i);
      if (i < 0 || i >= q.size()) return -1;
      return q[i];
   endfunction

   function automatic int qsum(input int q [$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s;
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      m_line.delete();
      m_active = 1'b0;
      m_serial = 1'b1;
      m_sticky = 1'b0;
      m_drops  = 0;
   endtask

   task automatic model_edge();
      logic [15:0] head;
      bit dropped;
      dropped = 1'b0;
      if (!m_active && tx_enable && m_fifo.size() != 0) begin
         head = m_fifo.pop_front();
         repeat (D) m_line.push_back(1'b0);
         for (int b = 15; b >= 0; b--) repeat (D) m_line.push_back(head[b]);
`ifdef ROW_PACKET_TX_PARITY_EN
         repeat (D) m_line.push_back(^head);
`endif
         repeat (D) m_line.push_back(1'b1);
      end
      if (pkt_valid) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(pkt_in);
         else dropped = 1'b1;
      end
      if (dropped) begin
         m_sticky = 1'b1;
         m_drops  = clear_ovf ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (clear_ovf) begin
         m_sticky = 1'b0;
         m_drops  = 0;
      end
      if (m_line.size() > 0) begin
         m_serial = m_line.pop_front();
         m_active = 1'b1;
      end else begin
         m_serial = 1'b1;
         m_active = 1'b0;
      end
   endtask

   task automatic model_cmp();
      logic [17:0] a;
      logic [17:0] e;
      a = {serial_out, frame_active, fifo_full, overflow_sticky, 6'(fifo_level), drop_count};
      e = {m_serial, m_active, (m_fifo.size() == DEPTH), m_sticky, 6'(m_fifo.size()), 8'(m_drops)};
      chk($sformatf("cycle model t=%0t {ser,act,full,ovf,lvl,drops}", $time), 32'(a), 32'(e));
   endtask

   task automatic step(input bit v, input logic [15:0] d, input bit en, input bit clr);
      pkt_valid = v;
      pkt_in    = d;
      tx_enable = en;
      clear_ovf = clr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      model_cmp();
      q_ser.push_back(int'(serial_out));
      q_act.push_back(int'(frame_active));
      q_lvl.push_back(int'(fifo_level));
   endtask

   task automatic q_clear();
      q_ser.delete();
      q_act.delete();
      q_lvl.delete();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      pkt_valid = 1'b0;
      pkt_in    = '0;
      tx_enable = 1'b0;
      clear_ovf = 1'b0;
      model_reset();
      q_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_frame(input string name, input int s, input logic [15:0] w);
      chk({name, " start bit"}, qget(q_ser, s + D/2), 0);
      for (int b = 0; b < 16; b++)
         chk($sformatf("%s data bit %0d", name, b), qget(q_ser, s + D + b*D + D/2), int'(w[15-b]));
`ifdef ROW_PACKET_TX_PARITY_EN
      chk({name, " parity bit"}, qget(q_ser, s + 17*D + D/2), int'(^w));
`endif
      chk({name, " stop bit"}, qget(q_ser, s + FL - D + D/2), 1);
      chk({name, " active last cycle"}, qget(q_act, s + FL - 1), 1);
      chk({name, " inactive after"}, qget(q_act, s + FL), 0);
   endtask

   function automatic int find_low(input int q [$], input int from);
      for (int i = from; i < q.size(); i++) if (q[i] == 0) return i;
      return -1;
   endfunction

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s1;
      int s2;
      int burst;
      bit en_r;
      bit v;

      // Reset values
      do_reset();
      chk("reset serial_out", serial_out, 1);
      chk("reset frame_active", frame_active, 0);
      chk("reset fifo_level", fifo_level, 0);
      chk("reset fifo_full", fifo_full, 0);
      chk("reset overflow_sticky", overflow_sticky, 0);
      chk("reset drop_count", drop_count, 0);

      // Single packet 0x2A5B: IDLE pop cycle, then full frame
      step(1'b1, 16'h2A5B, 1'b1, 1'b0);
      repeat (FL + 6) step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("A level after write", qget(q_lvl, 0), 1);
      chk("A line during idle pop", qget(q_ser, 0), 1);
      chk("A inactive during idle pop", qget(q_act, 0), 0);
      chk("A level after pop", qget(q_lvl, 1), 0);
      chk("A active cycles", qsum(q_act), FL);
      for (int c = 0; c < FL; c++) begin
         int ex;
         if (c < D) ex = 0;
         else if (c < 17*D) ex = int'(a_bits[(c - D) / D]);
`ifdef ROW_PACKET_TX_PARITY_EN
         else if (c < 18*D) ex = 0;
`endif
         else ex = 1;
         chk($sformatf("A line cycle %0d", c), qget(q_ser, 1 + c), ex);
      end
      chk("A line after frame", qget(q_ser, 1 + FL), 1);

      // Vector table: fill, overflow, clear, clear-vs-drop, pop with simultaneous write
      do_reset();
      for (int i = 1; i <= 16; i++)
         vt.push_back('{1'b1, 16'(i), 1'b0, 1'b0, i, (i == 16), 1'b0, 0});
      vt.push_back('{1'b1, 16'h0011, 1'b0, 1'b0, 16, 1'b1, 1'b1, 1});
      vt.push_back('{1'b1, 16'h0012, 1'b0, 1'b0, 16, 1'b1, 1'b1, 2});
      vt.push_back('{1'b0, 16'h0000, 1'b0, 1'b1, 16, 1'b1, 1'b0, 0});
      vt.push_back('{1'b1, 16'h0013, 1'b0, 1'b1, 16, 1'b1, 1'b1, 1});
      vt.push_back('{1'b0, 16'h0000, 1'b0, 1'b0, 16, 1'b1, 1'b1, 1});
      vt.push_back('{1'b1, 16'h0099, 1'b1, 1'b0, 16, 1'b1, 1'b1, 1});
      vt.push_back('{1'b1, 16'h00AA, 1'b1, 1'b0, 16, 1'b1, 1'b1, 2});
      vt.push_back('{1'b0, 16'h0000, 1'b1, 1'b0, 16, 1'b1, 1'b1, 2});
      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].v, vt[i].d, vt[i].en, vt[i].clr);
         chk($sformatf("vec%0d fifo_level", i), fifo_level, vt[i].lvl);
         chk($sformatf("vec%0d fifo_full", i), fifo_full, vt[i].full);
         chk($sformatf("vec%0d overflow_sticky", i), overflow_sticky, vt[i].sticky);
         chk($sformatf("vec%0d drop_count", i), drop_count, vt[i].drops);
      end
      repeat (17 * (FL + 1) + 10) step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("drain fifo_level", fifo_level, 0);

      // Back-to-back frames with a single idle gap
      do_reset();
      step(1'b1, 16'h8000, 1'b0, 1'b0);
      step(1'b1, 16'h8123, 1'b0, 1'b0);
      q_clear();
      repeat (2*FL + 10) step(1'b0, 16'h0, 1'b1, 1'b0);
      s1 = find_low(q_ser, 0);
      chk("gap first start index", s1, 0);
      check_frame("pkt 8000", s1, 16'h8000);
      s2 = find_low(q_ser, s1 + FL);
      chk("gap cycles between frames", s2 - (s1 + FL), 1);
      check_frame("pkt 8123", s2, 16'h8123);

`ifdef ROW_PACKET_TX_PARITY_EN
      do_reset();
      step(1'b1, 16'h0007, 1'b1, 1'b0);
      repeat (FL + 6) step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("parity active cycles", qsum(q_act), 19*D);
      chk("parity bit of 0007", qget(q_ser, 1 + 17*D + D/2), 1);
      check_frame("pkt 0007", 1, 16'h0007);
`endif

      // Reset during data bit 7 of the first of three buffered packets
      do_reset();
      step(1'b1, 16'h1234, 1'b0, 1'b0);
      step(1'b1, 16'h5678, 1'b0, 1'b0);
      step(1'b1, 16'h9ABC, 1'b0, 1'b0);
      q_clear();
      repeat (D + 7*D + 2) step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("mid frame active before reset", frame_active, 1);
      chk("mid frame bit7 before reset", serial_out, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset serial_out async", serial_out, 1);
      chk("mid reset frame_active", frame_active, 0);
      chk("mid reset fifo_level", fifo_level, 0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q_clear();
      repeat (150) step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("no frame after reset release", qsum(q_act), 0);

      // Random: heavy load to saturate drop_count, then mixed traffic with clears and enable gaps
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(1)), 16'($urandom), 1'b1, 1'b0);
      chk("drop_count saturated", drop_count, 255);
      burst = 0;
      en_r  = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(99) == 0) en_r = !en_r;
         if (burst == 0 && $urandom_range(199) == 0) burst = $urandom_range(24, 8);
         v = (burst > 0) || ($urandom_range(29) == 0);
         if (burst > 0) burst--;
         step(v, 16'($urandom), en_r, ($urandom_range(79) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/row_packet_tx.md
Name: row_packet_tx

Overview:
- Downstream stage of the 5-pixel row encoder.
- Takes its 16-bit packets: raw 0_xxx..., timestamp 1_ttt..., and the 0x8000 wrap marker.
- Buffers packets in a small FIFO, then serialises each one onto a single off-chip line using UART-style framing (start bit, 16 data bits MSB first, stop bit).
- Absorbs encoder bursts and reports packet loss when the line cannot keep up.

Parameters:
- FIFO_DEPTH, 16, number of 16-bit packet entries; power of two, at least 2.
- ADDR_W, 4, equal to log2(FIFO_DEPTH).
- CLK_DIV, 4, clk cycles each serial bit is held; at least 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- pkt_in  input  16  encoded packet from the row encoder
- pkt_valid  input  1  single-cycle strobe; pkt_in is valid (the encoder's data_ready)
- tx_enable  input  1  allows new frames to start
- clear_ovf  input  1  single-cycle clear of overflow_sticky and drop_count
- serial_out  output  1  serial line; idles high
- frame_active  output  1  high while a frame is on the line
- fifo_level  output  ADDR_W+1  number of stored packets
- fifo_full  output  1  high when fifo_level == FIFO_DEPTH
- overflow_sticky  output  1  set when any packet has been dropped
- drop_count  output  8  number of dropped packets, saturating at 255

Behaviour:
- Reset values:
  - serial_out=1; all other outputs 0.
  - FIFO empty, read/write pointers 0, FSM in IDLE, bit and divider counters 0.
  - Reset asserted mid-frame aborts the frame at once: serial_out=1 asynchronously and stored packets are discarded.
- Write:
  - On pkt_valid with space available, pkt_in is stored at the write pointer. The pointer wraps modulo FIFO_DEPTH.
  - "Space available" means fifo_level < FIFO_DEPTH, or a pop happens in the same cycle. Full plus simultaneous pop means the write is accepted.
  - On pkt_valid with no space, the packet is dropped:
    - drop_count increments, saturating at 255;
    - overflow_sticky sets;
    - FIFO contents are unchanged.
- fifo_level:
  - +1 on write only, -1 on pop only, unchanged on both or neither.
  - fifo_level and fifo_full are registered and update the cycle after the event.
- clear_ovf:
  - Zeroes overflow_sticky and drop_count next cycle.
  - If a drop happens in the same cycle, the drop wins: sticky=1, count=1.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - serial_out=1, frame_active=0.
    - If tx_enable=1 and fifo_level != 0, pop the head into a 16-bit shift register, go to START next cycle, and set frame_active=1.
    - A write into an empty FIFO is popped at the earliest on the following cycle.
  - START: serial_out=0 for CLK_DIV cycles, then DATA.
  - DATA:
    - serial_out = shift_reg[15]; shift left each time the divider expires.
    - Bit counter runs 0..15; after 16 bits, go to STOP.
  - STOP: serial_out=1 for CLK_DIV cycles, then IDLE.
  - Frame length is 18*CLK_DIV cycles. IDLE always lasts at least 1 cycle, so back-to-back frames are separated by one extra high cycle.
- Divider: counts 0..CLK_DIV-1 and resets on each state entry. With CLK_DIV=1, each bit lasts exactly one cycle.
- tx_enable low mid-frame: the current frame completes; no new pop. Buffered packets are held.
- serial_out and frame_active are driven from registers (no combinational path from inputs).
- Packet contents are not interpreted; 0x8000 and timestamps are sent like any other packet.

Optional Feature:
- Macro ROW_PACKET_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, lasting CLK_DIV cycles.
  - It transmits even parity, the XOR of the 16 data bits.
  - Frame length becomes 19*CLK_DIV.
- Undefined: no parity bit; 18*CLK_DIV frame; no parity logic synthesised.

Test Plan:
- Reset; tx_enable=1; single pkt_in=0x2A5B → serial_out sequence:
  - idle high, 1 cycle of IDLE pop;
  - start 0 for 4 cycles;
  - bits 0,0,1,0,1,0,1,0,0,1,0,1,1,0,1,1, 4 cycles each;
  - stop 1 for 4 cycles.
  - frame_active high for 72 cycles; fifo_level goes 1 then 0.
- tx_enable=0; write 17 packets 0x0001..0x0011 → fifo_full=1 after the 16th; the 17th is dropped; drop_count=1; overflow_sticky=1; FIFO holds 0x0001..0x0010.
- From full with tx_enable=1: a pkt_valid in the same cycle as the IDLE pop → accepted; fifo_level stays 16; drop_count unchanged.
- Two packets 0x8000 and 0x8123 queued → two frames with exactly one high gap cycle between the STOP end and the next START; data matches MSB first.
- Assert rst_n low during DATA bit 7 → serial_out=1 immediately; fifo_level=0; no frame resumes after release.
- With ROW_PACKET_TX_PARITY_EN, packet 0x0007 → parity bit 1; frame length 76 cycles at CLK_DIV=4.
